// File: rtl/riscv_pkg.sv
// Shared types and helpers for the pipeline stages.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

  // Data-memory port controller states.
  typedef enum logic [1:0] {
    ME_IDLE,
    ME_WAIT,
    ME_DONE
  } me_state_t;

  // Branch resolution: taken when the zero test of the ALU result matches check_eq.
  function automatic logic branch_taken(input logic branch,
                                        input logic check_eq,
                                        input logic is_zero);
    return branch & (is_zero == check_eq);
  endfunction

endpackage

// File: rtl/dmem_port_fsm.sv
// Data-memory request/acknowledge controller with timeout and rdata hold register.
// Latency: zero-wait completion on a same-cycle ack; otherwise completes on ack or timeout.
// Backpressure: stall_o holds the pipeline while an access is outstanding; latch_en_i=0
//   at completion parks the read data in the hold register until the WB latch opens.
// Ports: acc_i/ack_i/rdata_i from the stage and bus, latch_en_i/latch_clear_i from HU,
//   req_o/stall_o/rdata_o (value for the ME/WB latch) and sticky bus_err_o.
module dmem_port_fsm import riscv_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              latch_en_i,
  input  logic              latch_clear_i,
  output logic              req_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  me_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              req;
  logic              timeout;

  // An ack in the last allowed cycle still counts as a normal completion.
  assign timeout = (state_q == ME_WAIT) & ~ack_i & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ME_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      ME_IDLE: begin
        if (acc_i) begin
          if (!ack_i) begin
            state_d = ME_WAIT;
            cnt_d   = '0;
          end else if (!latch_en_i) begin
            state_d = ME_DONE;
            hold_d  = rdata_i;
          end
        end
      end
      ME_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (latch_clear_i) begin
          state_d = ME_IDLE;
        end else if (ack_i || timeout) begin
          if (timeout) err_d = 1'b1;
          if (latch_en_i) begin
            state_d = ME_IDLE;
          end else begin
            state_d = ME_DONE;
            hold_d  = ack_i ? rdata_i : '0;
          end
        end
      end
      ME_DONE: begin
        if (latch_en_i) state_d = ME_IDLE;
      end
      default: state_d = ME_IDLE;
    endcase
  end

  always_comb begin
    req     = 1'b0;
    stall_o = 1'b0;
    rdata_o = '0;
    unique case (state_q)
      ME_IDLE: begin
        req     = acc_i;
        stall_o = acc_i & ~ack_i;
        rdata_o = (acc_i & ack_i) ? rdata_i : '0;
      end
      ME_WAIT: begin
        req     = ~timeout & ~latch_clear_i;
        stall_o = ~ack_i & ~timeout & ~latch_clear_i;
        rdata_o = ack_i ? rdata_i : '0;
      end
      ME_DONE: begin
        rdata_o = hold_q;
      end
      default: ;
    endcase
  end

  // Request is gated by reset so it drops immediately, even with an access still presented.
  assign req_o     = reset & req;
  assign bus_err_o = err_q;

endmodule

// File: rtl/latch.sv
// Generic pipeline latch with synchronous clear and enable.
// Latency: 1 cycle from d_i to q_o when en_i=1.
// Backpressure: en_i=0 holds the current value; clear_i wins over en_i.
// Ports: clk, reset (async active-low), en_i, clear_i, d_i[W], q_o[W].
module latch #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (clear_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline ME stage: drives the data-memory bus, resolves branches, feeds ME/WB, bypass and HU.
// Latency: load data appears at WB one cycle after the ack cycle; zero-wait loads add no bubble.
// Backpressure: mem_stall_o freezes IF..ME while an access is outstanding (bounded by a timeout).
// Ports: EX/ME inputs (*_i), dmem bus (dmem_*), HU latch control (latch_en_i/latch_clear_i),
//   IF redirect (pc_src_o/pc_branch_o), ME/WB outputs, bypass/HU taps, stall and bus error.
module memory_stage import riscv_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_we_i,
  input  logic              mem_we_i,
  input  logic              mem2rf_i,
  input  logic              branch_i,
  input  logic              check_eq_i,
  input  logic              jump_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [PC_W-1:0]   pc_branch_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              latch_en_i,
  input  logic              latch_clear_i,
  output logic              pc_src_o,
  output logic [PC_W-1:0]   pc_branch_o,
  output logic              rf_we_o,
  output logic              mem2rf_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic [DATA_W-1:0] rf_data_m_o,
  output logic [ADDR_W-1:0] rf_dst_o,
  output logic              rf_we_hu_o,
  output logic              mem_stall_o,
  output logic              bus_err_o
);

  localparam int LW = 2 + ADDR_W + 2 * DATA_W;

  logic              acc;
  logic [DATA_W-1:0] rdata_m;
  logic [LW-1:0]     mewb_d, mewb_q;

  assign acc = mem_we_i | mem2rf_i;

  dmem_port_fsm #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_port (
    .clk           (clk),
    .reset         (reset),
    .acc_i         (acc),
    .ack_i         (dmem_ack_i),
    .rdata_i       (dmem_rdata_i),
    .latch_en_i    (latch_en_i),
    .latch_clear_i (latch_clear_i),
    .req_o         (dmem_req_o),
    .stall_o       (mem_stall_o),
    .rdata_o       (rdata_m),
    .bus_err_o     (bus_err_o)
  );

  // EX/ME is frozen while stalled, so the bus qualifiers stay stable for the whole access.
  assign dmem_we_o    = mem_we_i;
  assign dmem_addr_o  = alu_result_i;
  assign dmem_wdata_o = mem_wdata_i;

  assign pc_src_o    = jump_i | branch_taken(branch_i, check_eq_i, alu_result_i == '0);
  assign pc_branch_o = pc_branch_i;

  assign rf_data_m_o = alu_result_i;
  assign rf_dst_o    = rf_waddr_i;
  assign rf_we_hu_o  = rf_we_i;

  assign mewb_d = {rf_we_i, mem2rf_i, rf_waddr_i, alu_result_i, rdata_m};

  latch #(.W(LW)) u_mewb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (latch_en_i),
    .clear_i (latch_clear_i),
    .d_i     (mewb_d),
    .q_o     (mewb_q)
  );

  assign {rf_we_o, mem2rf_o, rf_waddr_o, alu_result_o, mem_rdata_o} = mewb_q;

endmodule
